// File: rtl/pipelined_addsub.sv
// Carry-pipelined adder/subtractor, CHUNK bits resolved per stage.
// Define ADDSUB_OVERFLOW_EN to compute and register signed overflow.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;

  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] ai [STAGES];
  logic [WIDTH-1:0] bi [STAGES];
  logic [WIDTH-1:0] si [STAGES];
  logic             ci [STAGES];
  logic             vi [STAGES];

  logic [WIDTH-1:0] sn [STAGES];
  logic             co [STAGES];
  logic             cy;

  // stage 0 takes the ports directly; B is pre-inverted for subtract
  always_comb begin
    ai[0] = a;
    bi[0] = sub ? ~b : b;
    ci[0] = cin ^ sub;
    vi[0] = in_valid;
    si[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      ai[k] = a_q[k-1];
      bi[k] = b_q[k-1];
      ci[k] = c_q[k-1];
      vi[k] = v_q[k-1];
      si[k] = s_q[k-1];
    end
  end

  always_comb begin
    cy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      cy    = ci[k];
      sn[k] = si[k];
      for (int i = 0; i < WIDTH; i++) begin
        if (i / CHUNK == k) begin
          sn[k][i] = ai[k][i] ^ bi[k][i] ^ cy;
          cy = (ai[k][i] & bi[k][i])
             | (cy & (ai[k][i] ^ bi[k][i]));
        end
      end
      co[k] = cy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= ai[k];
        b_q[k] <= bi[k];
        s_q[k] <= sn[k];
        c_q[k] <= co[k];
        v_q[k] <= vi[k];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

`ifdef ADDSUB_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  // last stage still sees the untouched sign bits of A and B'
  always_comb begin
    ovf_d = (ai[STAGES-1][WIDTH-1] == bi[STAGES-1][WIDTH-1])
         && (sn[STAGES-1][WIDTH-1] != ai[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     ovf_q <= 1'b0;
    else if (en) ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: 16/4 and 10/4 instances,
// queue scoreboard plus per-scenario timing checks.
module tb_pipelined_addsub;

`ifdef ADDSUB_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en;

  logic        v16, cin16, sub16;
  logic [15:0] a16, b16;
  logic        ov16, co16, of16;
  logic [15:0] s16;

  logic        v10, cin10, sub10;
  logic [9:0]  a10, b10;
  logic        ov10, co10, of10;
  logic [9:0]  s10;

  int checks = 0;
  int errors = 0;

  logic [17:0] q16[$];
  logic [11:0] q10[$];

  pipelined_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .in_valid(v16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .s(s16), .cout(co16), .ovf(of16)
  );

  pipelined_addsub #(.WIDTH(10), .CHUNK(4)) dut10 (
    .clk(clk), .rst(rst), .en(en), .in_valid(v10),
    .a(a10), .b(b10), .cin(cin10), .sub(sub10),
    .out_valid(ov10), .s(s10), .cout(co10), .ovf(of10)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] model16(
    input logic [15:0] a, b, input logic c, sb);
    logic [15:0] bb;
    logic [16:0] f;
    logic        o;
    bb = sb ? ~b : b;
    f  = {1'b0, a} + {1'b0, bb} + {16'b0, c ^ sb};
    o  = OVF & (a[15] == bb[15]) & (f[15] != a[15]);
    return {o, f[16], f[15:0]};
  endfunction

  function automatic logic [11:0] model10(
    input logic [9:0] a, b, input logic c, sb);
    logic [9:0]  bb;
    logic [10:0] f;
    logic        o;
    bb = sb ? ~b : b;
    f  = {1'b0, a} + {1'b0, bb} + {10'b0, c ^ sb};
    o  = OVF & (a[9] == bb[9]) & (f[9] != a[9]);
    return {o, f[10], f[9:0]};
  endfunction

  // scoreboard: every valid output on an enabled edge pops one entry
  always @(posedge clk) begin
    #1;
    if (!rst && en) begin
      if (ov16) begin
        checks++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL sb16 extra result got=%h", {of16, co16, s16});
        end else begin
          logic [17:0] e;
          e = q16.pop_front();
          if ({of16, co16, s16} !== e) begin
            errors++;
            $display("FAIL sb16 got=%h exp=%h", {of16, co16, s16}, e);
          end
        end
      end
      if (ov10) begin
        checks++;
        if (q10.size() == 0) begin
          errors++;
          $display("FAIL sb10 extra result got=%h", {of10, co10, s10});
        end else begin
          logic [11:0] e;
          e = q10.pop_front();
          if ({of10, co10, s10} !== e) begin
            errors++;
            $display("FAIL sb10 got=%h exp=%h", {of10, co10, s10}, e);
          end
        end
      end
    end
  end

  task automatic cyc16(input logic e, v, input logic [15:0] a, b,
                       input logic c, sb);
    @(negedge clk);
    en = e; v16 = v; a16 = a; b16 = b; cin16 = c; sub16 = sb;
    v10 = 1'b0;
    if (e && v) q16.push_back(model16(a, b, c, sb));
    @(posedge clk);
    #1;
  endtask

  task automatic cyc10(input logic e, v, input logic [9:0] a, b,
                       input logic c, sb);
    @(negedge clk);
    en = e; v10 = v; a10 = a; b10 = b; cin10 = c; sub10 = sb;
    v16 = 1'b0;
    if (e && v) q10.push_back(model10(a, b, c, sb));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({ov16, co16, of16, s16} !== 19'd0) begin
      errors++;
      $display("FAIL reset16 got=%h exp=0", {ov16, co16, of16, s16});
    end
    checks++;
    if ({ov10, co10, of10, s10} !== 13'd0) begin
      errors++;
      $display("FAIL reset10 got=%h exp=0", {ov10, co10, of10, s10});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    cyc16(1, 1, 16'h00FF, 16'h0001, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov16 !== 1'b0) begin
        errors++;
        $display("FAIL basic_early edge=%0d ov=%b exp=0", i, ov16);
      end
      if (i < 2) cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, co16, of16, s16} !== {3'b100, 16'h0100}) begin
      errors++;
      $display("FAIL basic got=%h exp=%h",
               {ov16, co16, of16, s16}, {3'b100, 16'h0100});
    end
  endtask

  task automatic test_back_to_back;
    cyc16(1, 1, 16'hFFFF, 16'h0001, 0, 0);
    cyc16(1, 1, 16'h1234, 16'h4321, 1, 0);
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, co16, of16, s16} !== {3'b110, 16'h0000}) begin
      errors++;
      $display("FAIL b2b_first got=%h exp=%h",
               {ov16, co16, of16, s16}, {3'b110, 16'h0000});
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, co16, of16, s16} !== {3'b100, 16'h5556}) begin
      errors++;
      $display("FAIL b2b_second got=%h exp=%h",
               {ov16, co16, of16, s16}, {3'b100, 16'h5556});
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (ov16 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_bubble ov=%b exp=0", ov16);
    end
  endtask

  task automatic test_sub;
    cyc16(1, 1, 16'h0005, 16'h0007, 0, 1);
    cyc16(1, 1, 16'h8000, 16'h0001, 0, 1);
    cyc16(1, 1, 16'h7FFF, 16'h0001, 0, 0);
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, co16, of16, s16} !== {3'b100, 16'hFFFE}) begin
      errors++;
      $display("FAIL sub_neg got=%h exp=%h",
               {ov16, co16, of16, s16}, {3'b100, 16'hFFFE});
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, co16, of16, s16} !== {2'b11, OVF, 16'h7FFF}) begin
      errors++;
      $display("FAIL sub_ovf got=%h exp=%h",
               {ov16, co16, of16, s16}, {2'b11, OVF, 16'h7FFF});
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, co16, of16, s16} !== {2'b10, OVF, 16'h8000}) begin
      errors++;
      $display("FAIL add_ovf got=%h exp=%h",
               {ov16, co16, of16, s16}, {2'b10, OVF, 16'h8000});
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
  endtask

  task automatic test_stall;
    logic [18:0] held;
    cyc16(1, 1, 16'h1111, 16'h2222, 0, 0);
    cyc16(1, 1, 16'hABCD, 16'h1234, 1, 1);
    cyc16(1, 1, 16'h0F0F, 16'hF0F1, 0, 0);
    cyc16(1, 1, 16'h8001, 16'h0002, 0, 1);
    held = {ov16, co16, of16, s16};
    checks++;
    if (held !== {3'b100, 16'h3333}) begin
      errors++;
      $display("FAIL stall_pre got=%h exp=%h", held, {3'b100, 16'h3333});
    end
    for (int i = 0; i < 3; i++) begin
      cyc16(0, 1, 16'(($urandom)), 16'(($urandom)), 1, 0);
      checks++;
      if ({ov16, co16, of16, s16} !== held) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%h exp=%h",
                 i, {ov16, co16, of16, s16}, held);
      end
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, s16} !== {1'b1, 16'h9998}) begin
      errors++;
      $display("FAIL stall_b got=%h exp=%h", {ov16, s16}, {1'b1, 16'h9998});
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, s16} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL stall_c got=%h exp=%h", {ov16, s16}, {1'b1, 16'h0000});
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if ({ov16, s16} !== {1'b1, 16'h7FFF}) begin
      errors++;
      $display("FAIL stall_d got=%h exp=%h", {ov16, s16}, {1'b1, 16'h7FFF});
    end
    cyc16(1, 0, 16'h0, 16'h0, 0, 0);
    checks++;
    if (ov16 !== 1'b0) begin
      errors++;
      $display("FAIL stall_after ov=%b exp=0", ov16);
    end
  endtask

  task automatic test_reset_mid;
    cyc16(1, 1, 16'h0001, 16'h0001, 0, 0);
    cyc16(1, 1, 16'h0002, 16'h0002, 0, 0);
    cyc16(1, 1, 16'h0003, 16'h0003, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ov16, s16} !== 17'd0) begin
      errors++;
      $display("FAIL rst_async got=%h exp=0", {ov16, s16});
    end
    q16.delete();
    q10.delete();
    @(negedge clk);
    v16 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc16(1, 0, 16'h0, 16'h0, 0, 0);
      checks++;
      if (ov16 !== 1'b0) begin
        errors++;
        $display("FAIL rst_flush cyc=%0d ov=%b exp=0", i, ov16);
      end
    end
  endtask

  task automatic test_w10;
    cyc10(1, 1, 10'h3FF, 10'h001, 0, 0);
    checks++;
    if (ov10 !== 1'b0) begin
      errors++;
      $display("FAIL w10_early0 ov=%b exp=0", ov10);
    end
    cyc10(1, 0, 10'h0, 10'h0, 0, 0);
    checks++;
    if (ov10 !== 1'b0) begin
      errors++;
      $display("FAIL w10_early1 ov=%b exp=0", ov10);
    end
    cyc10(1, 1, 10'h000, 10'h001, 0, 1);
    checks++;
    if ({ov10, co10, of10, s10} !== {3'b110, 10'h000}) begin
      errors++;
      $display("FAIL w10_add got=%h exp=%h",
               {ov10, co10, of10, s10}, {3'b110, 10'h000});
    end
    cyc10(1, 0, 10'h0, 10'h0, 0, 0);
    cyc10(1, 0, 10'h0, 10'h0, 0, 0);
    checks++;
    if ({ov10, co10, of10, s10} !== {3'b100, 10'h3FF}) begin
      errors++;
      $display("FAIL w10_sub got=%h exp=%h",
               {ov10, co10, of10, s10}, {3'b100, 10'h3FF});
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      en    = ($urandom_range(3) != 0);
      v16   = $urandom_range(1);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = $urandom_range(1);
      sub16 = $urandom_range(1);
      v10   = $urandom_range(1);
      a10   = 10'($urandom);
      b10   = 10'($urandom);
      cin10 = $urandom_range(1);
      sub10 = $urandom_range(1);
      if (en && v16) q16.push_back(model16(a16, b16, cin16, sub16));
      if (en && v10) q10.push_back(model10(a10, b10, cin10, sub10));
    end
    @(negedge clk);
    en = 1'b1; v16 = 1'b0; v10 = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (q16.size() != 0 || q10.size() != 0) begin
      errors++;
      $display("FAIL drain pending16=%0d pending10=%0d exp=0",
               q16.size(), q10.size());
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0;
    v10 = 1'b0; a10 = '0; b10 = '0; cin10 = 1'b0; sub10 = 1'b0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_sub;
    test_stall;
    test_reset_mid;
    test_w10;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
